bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the sequence-detector path. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on bit_out, which drives bit_in of the 1100 pattern-detector FSM. A one-word pending register allows gapless back-to-back streaming. Whenever no word is being shifted, the line carries a fixed idle level.

## Interface
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 0: level driven on bit_out when bit_valid=0.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word; sampled only on an accepting edge.
- data_valid  input  1  upstream holds a word.
- data_ready  output  1  block can take a word this cycle; combinational = !pending_full && !rst.
- bit_out  output  1  serial bit, registered; connects to detector bit_in.
- bit_valid  output  1  bit_out carries word data this cycle, registered.
- busy  output  1  (state==SHIFT) || pending_full.

## Operation
- Storage:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt (clog2(WIDTH) bits)
  - pending register pend[WIDTH-1:0] with flag pending_full
  - state IDLE/SHIFT
- Accept: a word is taken on any edge where data_valid && data_ready.
- IDLE:
  - On accept, load sh from data_in, set cnt=0, go to SHIFT.
  - pend is not used.
- SHIFT, not on the last bit (cnt != WIDTH-1):
  - Each edge shifts sh by one in the send direction and increments cnt.
  - An accepted word goes into pend and sets pending_full.
- SHIFT, last-bit edge (cnt == WIDTH-1):
  - pending_full=1: load sh from pend, clear pending_full, cnt=0, stay in SHIFT.
  - pending_full=0 with a simultaneous accept: load sh directly from data_in, cnt=0, stay in SHIFT. pend stays empty.
  - Otherwise: go to IDLE.
- Outputs:
  - bit_out = sh[WIDTH-1] if MSB_FIRST, else sh[0], while in SHIFT.
  - bit_out = IDLE_BIT in IDLE.
  - bit_valid = (state==SHIFT).
- Upstream rule: data_in and data_valid must stay stable while data_valid=1 and data_ready=0. The block does not check this rule.
- Reset (any time, including mid-word):
  - state=IDLE, cnt=0, pending_full=0.
  - bit_out=IDLE_BIT, bit_valid=0, busy=0.
  - data_ready=0 while rst is high and 1 from the first cycle after release.
  - The partial word and any pending word are discarded. No partial word is resumed.

## Timing
- Latency: a word accepted at edge N drives its first bit from edge N to edge N+1. The last bit is driven from edge N+WIDTH-1 to edge N+WIDTH.
- A word occupies exactly WIDTH consecutive bit_valid cycles.
- Back-to-back: with pend filled before the last-bit edge, or a word presented on the last-bit edge, there is zero idle cycles between words.
- Throughput: one word per WIDTH cycles.
- data_ready stays low from the edge that fills pend until the last-bit edge that drains it. It is high again in the following cycle.
- The IDLE→SHIFT transition and the first bit_out value take effect on the same edge; there is no bubble.

## Test plan
- Single word, WIDTH=8, MSB_FIRST=1: 0xC5 accepted at edge N.
  - Required: bit_out = 1,1,0,0,0,1,0,1 on edges N..N+7 with bit_valid=1.
  - Then bit_out=0 and bit_valid=0 from edge N+8.
- Back-to-back: 0xCC then 0x33 offered while busy.
  - Required: 16 contiguous valid bits 11001100 00110011.
  - data_ready=0 while 0x33 is pending.
  - The downstream 1100 detector pulses at the correct bit positions.
- LSB_FIRST (MSB_FIRST=0): 0x0C.
  - Required: bit_out = 0,0,1,1,0,0,0,0.
- Last-bit accept: with pend empty, present 0xF0 exactly on the last-bit edge of 0x0F.
  - Required: gapless stream 00001111 11110000.
  - pending_full never sets.
- Reset mid-word: assert rst asynchronously at bit 3 of 0xAA while 0x55 is pending.
  - Required: bit_valid=0 and bit_out=IDLE_BIT immediately, without waiting for an edge.
  - After release, data_ready=1 and neither the remaining bits of 0xAA nor 0x55 are ever emitted.
- Stall: hold data_valid=1 with a constant word while pend is full.
  - Required: the word is accepted exactly once, on the edge where data_ready returns to 1.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the 1100 sequence detector.
// A one-word pending register lets consecutive words stream with no idle gap.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [WIDTH-1:0]   sh_r;
    logic [WIDTH-1:0]   sh_nx_s;
    logic [WIDTH-1:0]   shifted_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [WIDTH-1:0]   pend_r;
    logic [WIDTH-1:0]   pend_nx_s;
    logic               pend_full_r;
    logic               pend_full_nx_s;
    logic               bit_out_r;
    logic               bit_valid_r;
    logic               bit_nx_s;
    logic               accept_s;

    assign data_ready = !pend_full_r && !rst;
    assign accept_s   = data_valid && data_ready;
    assign bit_out    = bit_out_r;
    assign bit_valid  = bit_valid_r;
    assign busy       = (state_r == ST_SHIFT) || pend_full_r;

    // Shift register advanced by one position in the send direction.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted_s = {sh_r[WIDTH-2:0], 1'b0};
        end else begin
            shifted_s = {1'b0, sh_r[WIDTH-1:1]};
        end
    end

    // Next-state logic: load, shift, drain the pending word or fall idle.
    always_comb begin
        state_nx_s     = state_r;
        sh_nx_s        = sh_r;
        cnt_nx_s       = cnt_r;
        pend_nx_s      = pend_r;
        pend_full_nx_s = pend_full_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    sh_nx_s    = data_in;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    state_nx_s = ST_SHIFT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r != LAST_CNT) begin
                    sh_nx_s  = shifted_s;
                    cnt_nx_s = cnt_r + CNT_W'(1);
                    if (accept_s) begin
                        pend_nx_s      = data_in;
                        pend_full_nx_s = 1'b1;
                    end else begin
                        pend_full_nx_s = pend_full_r;
                    end
                end else if (pend_full_r) begin
                    sh_nx_s        = pend_r;
                    pend_full_nx_s = 1'b0;
                    cnt_nx_s       = {CNT_W{1'b0}};
                end else if (accept_s) begin
                    // Word arriving on the last-bit edge bypasses pend.
                    sh_nx_s  = data_in;
                    cnt_nx_s = {CNT_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_nx_s     = ST_IDLE;
                cnt_nx_s       = {CNT_W{1'b0}};
                pend_full_nx_s = 1'b0;
            end
        endcase
    end

    // Serial bit for the next cycle, taken from the next shift-register value.
    always_comb begin
        if (state_nx_s == ST_SHIFT) begin
            if (MSB_FIRST != 0) begin
                bit_nx_s = sh_nx_s[WIDTH-1];
            end else begin
                bit_nx_s = sh_nx_s[0];
            end
        end else begin
            bit_nx_s = IDLE_BIT;
        end
    end

    // State and output registers; reset discards any partial or pending word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sh_r        <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            pend_r      <= {WIDTH{1'b0}};
            pend_full_r <= 1'b0;
            bit_out_r   <= IDLE_BIT;
            bit_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            sh_r        <= sh_nx_s;
            cnt_r       <= cnt_nx_s;
            pend_r      <= pend_nx_s;
            pend_full_r <= pend_full_nx_s;
            bit_out_r   <= bit_nx_s;
            bit_valid_r <= (state_nx_s == ST_SHIFT);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances checked each
// cycle against a bit-queue model of the serial stream and handshake.
module tb_bit_serializer;

    localparam int   W    = 8;
    localparam logic IDLE = 1'b0;

    logic         clk;
    logic         rst;
    logic [W-1:0] din0, din1;
    logic         dv0, dv1;
    logic         rdy0, bo0, bv0, busy0;
    logic         rdy1, bo1, bv1, busy1;

    bit           q0[$];
    bit           q1[$];
    bit           acc0, acc1;
    logic [31:0]  obsw0, obsw1;
    int           obsn0, obsn1;
    int           errors = 0;
    int           checks = 0;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(IDLE)) dut_msb (
        .clk(clk), .rst(rst), .data_in(din0), .data_valid(dv0),
        .data_ready(rdy0), .bit_out(bo0), .bit_valid(bv0), .busy(busy0)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(IDLE)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(din1), .data_valid(dv1),
        .data_ready(rdy1), .bit_out(bo1), .bit_valid(bv1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // The model holds every bit still to be shown; the head is the current bit.
    // A word is accepted only while at most one word's worth of bits is queued.
    task automatic tick();
        bit a0, a1;
        a0 = dv0 && !rst && (q0.size() <= W);
        a1 = dv1 && !rst && (q1.size() <= W);
        @(posedge clk);
        if (q0.size() > 0) void'(q0.pop_front());
        if (q1.size() > 0) void'(q1.pop_front());
        if (a0) for (int i = 0; i < W; i++) q0.push_back(din0[W-1-i]);
        if (a1) for (int i = 0; i < W; i++) q1.push_back(din1[i]);
        acc0 = a0;
        acc1 = a1;
        #1;
        chk("valid_msb", 32'(bv0),   32'(q0.size() > 0));
        chk("bit_msb",   32'(bo0),   32'((q0.size() > 0) ? q0[0] : IDLE));
        chk("busy_msb",  32'(busy0), 32'(q0.size() > 0));
        chk("ready_msb", 32'(rdy0),  32'((q0.size() <= W) && !rst));
        chk("valid_lsb", 32'(bv1),   32'(q1.size() > 0));
        chk("bit_lsb",   32'(bo1),   32'((q1.size() > 0) ? q1[0] : IDLE));
        chk("busy_lsb",  32'(busy1), 32'(q1.size() > 0));
        chk("ready_lsb", 32'(rdy1),  32'((q1.size() <= W) && !rst));
        if (bv0) begin obsw0 = {obsw0[30:0], bo0}; obsn0++; end
        if (bv1) begin obsw1 = {obsw1[30:0], bo1}; obsn1++; end
    endtask

    task automatic send(input int sel, input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        if (sel == 0) begin dv0 = 1'b1; din0 = w; end
        else begin dv1 = 1'b1; din1 = w; end
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            done = (sel == 0) ? acc0 : acc1;
        end
        dv0 = 1'b0;
        dv1 = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed=not_accepted expected=accepted");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && (q0.size() > 0 || q1.size() > 0); i++) tick();
        tick();
    endtask

    task automatic clear_obs();
        obsw0 = 32'h0; obsn0 = 0;
        obsw1 = 32'h0; obsn1 = 0;
    endtask

    initial begin
        logic [15:0] hits;
        rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0; din0 = '0; din1 = '0;
        acc0 = 1'b0; acc1 = 1'b0;
        clear_obs();
        #1;
        chk("rst_valid", 32'(bv0), 32'h0);
        chk("rst_bit",   32'(bo0), 32'(IDLE));
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_ready", 32'(rdy0), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst_msb", 32'(rdy0), 32'h1);
        chk("ready_after_rst_lsb", 32'(rdy1), 32'h1);

        // Single word, MSB first.
        clear_obs();
        send(0, 8'hC5);
        drain();
        chk("c5_len",  32'(obsn0), 32'd8);
        chk("c5_bits", obsw0, 32'h0000_00C5);

        // Back-to-back through the pending register.
        clear_obs();
        send(0, 8'hCC);
        send(0, 8'h33);
        chk("ready_low_pending", 32'(rdy0), 32'h0);
        drain();
        chk("b2b_len",  32'(obsn0), 32'd16);
        chk("b2b_bits", obsw0, 32'h0000_CC33);
        hits = 16'h0;
        for (int i = 3; i < 16; i++) begin
            logic [31:0] win;
            win = obsw0 >> (15 - i);
            hits[i] = (win[3:0] == 4'b1100);
        end
        chk("detector_hits", 32'(hits), 32'h0000_2088);

        // LSB-first instance.
        clear_obs();
        send(1, 8'h0C);
        drain();
        chk("lsb_len",  32'(obsn1), 32'd8);
        chk("lsb_bits", obsw1, 32'h0000_0030);

        // Word presented exactly on the last-bit edge, pend empty.
        clear_obs();
        send(0, 8'h0F);
        repeat (7) tick();
        dv0 = 1'b1; din0 = 8'hF0;
        tick();
        dv0 = 1'b0;
        chk("lastbit_ready", 32'(rdy0), 32'h1);
        drain();
        chk("lastbit_len",  32'(obsn0), 32'd16);
        chk("lastbit_bits", obsw0, 32'h0000_0FF0);

        // Asynchronous reset at bit 3 of 0xAA with 0x55 pending.
        clear_obs();
        send(0, 8'hAA);
        send(0, 8'h55);
        tick();
        tick();
        #3;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("arst_valid", 32'(bv0), 32'h0);
        chk("arst_bit",   32'(bo0), 32'(IDLE));
        chk("arst_busy",  32'(busy0), 32'h0);
        chk("arst_ready", 32'(rdy0), 32'h0);
        clear_obs();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("arst_release_ready", 32'(rdy0), 32'h1);
        repeat (20) tick();
        chk("arst_no_resume", 32'(obsn0), 32'd0);

        // Stall: third word held while pend is full, accepted exactly once.
        clear_obs();
        send(0, 8'h96);
        send(0, 8'h3C);
        send(0, 8'hE1);
        drain();
        chk("stall_len",  32'(obsn0), 32'd24);
        chk("stall_bits", obsw0, 32'h0096_3CE1);

        // Randomized traffic on both instances.
        for (int n = 0; n < 400; n++) begin
            if (!dv0 && ($urandom_range(0, 1) == 1)) begin dv0 = 1'b1; din0 = 8'($urandom); end
            if (!dv1 && ($urandom_range(0, 2) != 0)) begin dv1 = 1'b1; din1 = 8'($urandom); end
            tick();
            if (acc0) dv0 = 1'b0;
            if (acc1) dv1 = 1'b0;
        end
        dv0 = 1'b0;
        dv1 = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
